// File: rtl/cipher_pkg.sv
// Shared definitions for the encryption pipeline: character width, the NUL
// terminator value and the ciphertext buffer output-FSM states.
package cipher_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam logic [CHAR_W-1:0] NUL_CHAR = 8'h00;

  typedef enum logic [1:0] {
    HOLD,
    SEND,
    FORCE
  } buf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with wrap-bit pointers.
// dout_o reads as zero while empty so the head never shows stale storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A push into a full FIFO is accepted only when a pop frees the slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW + 1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/ciphertext_buffer.sv
// Buffers ciphertext characters with message boundaries, drops and counts
// invalid characters, and streams them out cut-through or store-and-forward.
module ciphertext_buffer
  import cipher_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned STORE_FWD = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 C_ready,
  input  logic [CHAR_W-1:0]    Char_ciphertext,
  input  logic                 err_invalid_ptxt,
  input  logic                 msg_end,
  output logic [CHAR_W-1:0]    out_data,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 full,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              wr_req, wr_last;
  logic [CHAR_W-1:0] wr_char;
  logic              pop, push_ok, empty;
  logic [CHAR_W:0]   head;

  logic [CW-1:0]          msg_cnt_q, msg_cnt_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic                   overflow_q, overflow_d;
  buf_state_t             state_q, state_d;

  always_comb begin
    wr_req  = 1'b0;
    wr_last = 1'b0;
    wr_char = NUL_CHAR;
    if (C_ready && !err_invalid_ptxt) begin
      wr_req  = 1'b1;
      wr_char = Char_ciphertext;
      wr_last = msg_end;
    end else if (msg_end) begin
      // Boundary with no character of its own: emit a NUL terminator.
      wr_req  = 1'b1;
      wr_last = 1'b1;
    end
  end

  assign pop     = out_valid && out_ready;
  assign push_ok = wr_req && (!full || pop);

  sync_fifo #(
    .WIDTH (CHAR_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_ok),
    .pop_i   (pop),
    .din_i   ({wr_char, wr_last}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_data = head[CHAR_W:1];
  assign out_last = head[0];

  always_comb begin
    msg_cnt_d = msg_cnt_q;
    unique case ({push_ok && wr_last, pop && out_last})
      2'b10:   msg_cnt_d = msg_cnt_q + CW'(1);
      2'b01:   msg_cnt_d = msg_cnt_q - CW'(1);
      default: msg_cnt_d = msg_cnt_q;
    endcase
  end

  always_comb begin
    err_count_d = err_count_q;
    if (C_ready && err_invalid_ptxt && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  assign overflow_d = overflow_q || (wr_req && full && !pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD: begin
        if (msg_cnt_q != '0) state_d = SEND;
        else if (full)       state_d = FORCE;
      end
      SEND, FORCE: begin
        if (pop && out_last && (msg_cnt_d == '0)) state_d = HOLD;
      end
      default: state_d = HOLD;
    endcase
  end

  assign out_valid = (STORE_FWD != 0) ? ((state_q != HOLD) && !empty) : !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_cnt_q   <= '0;
      err_count_q <= '0;
      overflow_q  <= 1'b0;
      state_q     <= HOLD;
    end else begin
      msg_cnt_q   <= msg_cnt_d;
      err_count_q <= err_count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
    end
  end

  assign overflow  = overflow_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ciphertext_buffer.sv
// Directed bench: a store-and-forward and a cut-through (2-bit error counter)
// instance share one stimulus stream; expected values are hand-computed.
module tb_ciphertext_buffer;

  logic       clk, rst;
  logic       C_ready, err_invalid_ptxt, msg_end, out_ready;
  logic [7:0] Char_ciphertext;

  logic [7:0] sf_data, ct_data;
  logic       sf_last, sf_valid, sf_full, sf_ovf;
  logic       ct_last, ct_valid, ct_full, ct_ovf;
  logic [7:0] sf_err;
  logic [1:0] ct_err;

  int passed = 0;
  int total  = 0;

  ciphertext_buffer #(.DEPTH(8), .ERR_CNT_W(8), .STORE_FWD(1)) u_sf (
    .clk              (clk),
    .rst              (rst),
    .C_ready          (C_ready),
    .Char_ciphertext  (Char_ciphertext),
    .err_invalid_ptxt (err_invalid_ptxt),
    .msg_end          (msg_end),
    .out_data         (sf_data),
    .out_last         (sf_last),
    .out_valid        (sf_valid),
    .out_ready        (out_ready),
    .full             (sf_full),
    .overflow         (sf_ovf),
    .err_count        (sf_err)
  );

  ciphertext_buffer #(.DEPTH(8), .ERR_CNT_W(2), .STORE_FWD(0)) u_ct (
    .clk              (clk),
    .rst              (rst),
    .C_ready          (C_ready),
    .Char_ciphertext  (Char_ciphertext),
    .err_invalid_ptxt (err_invalid_ptxt),
    .msg_end          (msg_end),
    .out_data         (ct_data),
    .out_last         (ct_last),
    .out_valid        (ct_valid),
    .out_ready        (out_ready),
    .full             (ct_full),
    .overflow         (ct_ovf),
    .err_count        (ct_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic strobe(input logic [7:0] c, input logic inv, input logic me);
    C_ready = 1'b1; Char_ciphertext = c; err_invalid_ptxt = inv; msg_end = me;
    @(negedge clk);
    C_ready = 1'b0; err_invalid_ptxt = 1'b0; msg_end = 1'b0; Char_ciphertext = 8'h00;
  endtask

  task automatic end_pulse();
    msg_end = 1'b1;
    @(negedge clk);
    msg_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; C_ready = 1'b0; err_invalid_ptxt = 1'b0; msg_end = 1'b0;
    Char_ciphertext = 8'h00; out_ready = 1'b0;
    idle(2);
    chk("rst_sf_valid", sf_valid, 0);
    chk("rst_sf_data", sf_data, 8'h00);
    chk("rst_sf_last", sf_last, 0);
    chk("rst_sf_full", sf_full, 0);
    chk("rst_sf_ovf", sf_ovf, 0);
    chk("rst_sf_err", sf_err, 0);
    chk("rst_ct_valid", ct_valid, 0);
    rst = 1'b0;

    // Cut-through vs store-and-forward on a two-character message
    out_ready = 1'b1;
    strobe(8'h47, 0, 0);
    chk("ct1_valid", ct_valid, 1);
    chk("ct1_data", ct_data, 8'h47);
    chk("ct1_last", ct_last, 0);
    chk("sf1_hold", sf_valid, 0);
    strobe(8'h48, 0, 1);
    chk("ct2_data", ct_data, 8'h48);
    chk("ct2_last", ct_last, 1);
    chk("sf2_hold", sf_valid, 0);
    idle(1);
    chk("ct3_empty", ct_valid, 0);
    chk("sf3_valid", sf_valid, 1);
    chk("sf3_data", sf_data, 8'h47);
    chk("sf3_last", sf_last, 0);
    idle(1);
    chk("sf4_data", sf_data, 8'h48);
    chk("sf4_last", sf_last, 1);
    idle(1);
    chk("sf5_empty", sf_valid, 0);

    // Store-and-forward holds until a standalone terminator arrives
    strobe(8'h61, 0, 0);
    strobe(8'h62, 0, 0);
    strobe(8'h63, 0, 0);
    chk("hold_a", sf_valid, 0);
    idle(2);
    chk("hold_b", sf_valid, 0);
    out_ready = 1'b0;
    end_pulse();
    chk("hold_c", sf_valid, 0);
    idle(1);
    chk("hold_rel_valid", sf_valid, 1);
    chk("hold_rel_data", sf_data, 8'h61);
    idle(1);
    chk("stall_valid", sf_valid, 1);
    chk("stall_data", sf_data, 8'h61);
    out_ready = 1'b1;
    idle(1);
    chk("hold_d62", sf_data, 8'h62);
    idle(1);
    chk("hold_d63", sf_data, 8'h63);
    chk("hold_l63", sf_last, 0);
    idle(1);
    chk("term_data", sf_data, 8'h00);
    chk("term_last", sf_last, 1);
    chk("term_valid", sf_valid, 1);
    idle(1);
    chk("term_empty", sf_valid, 0);

    // Invalid characters: dropped, counted, one terminator written
    do_reset();
    out_ready = 1'b0;
    strobe(8'h70, 1, 0);
    chk("inv_err1", sf_err, 1);
    chk("inv_nowrite", ct_valid, 0);
    strobe(8'h71, 1, 0);
    strobe(8'h72, 1, 0);
    strobe(8'h73, 1, 1);
    chk("inv_err4", sf_err, 4);
    chk("inv_sat_ct", ct_err, 3);
    chk("inv_term_valid", ct_valid, 1);
    chk("inv_term_data", ct_data, 8'h00);
    chk("inv_term_last", ct_last, 1);
    chk("inv_sf_hold", sf_valid, 0);
    idle(1);
    chk("inv_sf_valid", sf_valid, 1);
    chk("inv_sf_last", sf_last, 1);
    out_ready = 1'b1;
    idle(1);
    chk("inv_one_ct", ct_valid, 0);
    chk("inv_one_sf", sf_valid, 0);
    strobe(8'h74, 1, 0);
    chk("inv_err5", sf_err, 5);
    chk("inv_sat5_ct", ct_err, 3);

    // Overflow and forced release
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      strobe(8'(8'h10 + i), 0, 0);
      if (i == 6) chk("ovf_notfull7", sf_full, 0);
    end
    chk("ovf_full8", sf_full, 1);
    chk("ovf_clear8", sf_ovf, 0);
    strobe(8'h18, 0, 0);
    chk("ovf_set_sf", sf_ovf, 1);
    chk("ovf_set_ct", ct_ovf, 1);
    chk("force_valid", sf_valid, 1);
    chk("force_data", sf_data, 8'h10);
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      idle(1);
      chk("drain_data", sf_data, 32'(8'h10 + i));
    end
    chk("drain_ct_data", ct_data, 8'h17);
    idle(1);
    chk("drain_empty", sf_valid, 0);
    chk("ovf_sticky", sf_ovf, 1);

    // Full with simultaneous push and pop
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) strobe(8'(8'h10 + i), 0, 0);
    idle(1);
    chk("pp_force", sf_valid, 1);
    out_ready = 1'b1;
    strobe(8'h20, 0, 0);
    chk("pp_full_sf", sf_full, 1);
    chk("pp_ovf_sf", sf_ovf, 0);
    chk("pp_full_ct", ct_full, 1);
    chk("pp_ovf_ct", ct_ovf, 0);
    chk("pp_head", sf_data, 8'h11);
    for (int i = 2; i < 8; i++) begin
      idle(1);
      chk("pp_drain", sf_data, 32'(8'h10 + i));
    end
    idle(1);
    chk("pp_tail", sf_data, 8'h20);
    idle(1);
    chk("pp_empty", sf_valid, 0);

    // Asynchronous reset mid-message
    do_reset();
    out_ready = 1'b0;
    strobe(8'h2f, 1, 0);
    strobe(8'h30, 0, 0);
    strobe(8'h31, 0, 1);
    strobe(8'h32, 0, 0);
    strobe(8'h33, 0, 0);
    strobe(8'h34, 0, 0);
    chk("mid_pre_valid", sf_valid, 1);
    chk("mid_pre_err", sf_err, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_valid", sf_valid, 0);
    chk("mid_data", sf_data, 8'h00);
    chk("mid_last", sf_last, 0);
    chk("mid_full", sf_full, 0);
    chk("mid_err", sf_err, 0);
    chk("mid_ct_valid", ct_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    strobe(8'h40, 0, 1);
    chk("post_ct_data", ct_data, 8'h40);
    chk("post_ct_last", ct_last, 1);
    chk("post_sf_hold", sf_valid, 0);
    idle(1);
    chk("post_sf_data", sf_data, 8'h40);
    chk("post_sf_last", sf_last, 1);
    chk("post_ct_empty", ct_valid, 0);
    idle(1);
    chk("post_sf_empty", sf_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
